// File: rtl/tmr_adder_tree.sv
// rtl/tmr_adder_tree.sv - triple-redundant sign-magnitude adder tree with bitwise majority voter
// Optional fault-injection ports and logic are enabled by defining TMR_FAULT_INJECT_EN.

module tmr_adder_replica #(
  parameter int N_OPERANDS = 8,
  parameter int WIDTH      = 16
) (
  input  logic [N_OPERANDS*WIDTH-1:0] operand,
  output logic [WIDTH-1:0]            sum
);
  localparam int LEVELS = $clog2(N_OPERANDS);
  localparam int PAD    = 1 << LEVELS;
  localparam int SW     = WIDTH + LEVELS;
  localparam logic [SW-1:0] MAXV = {{(LEVELS + 1){1'b0}}, {(WIDTH - 1){1'b1}}};

  // Heap-ordered tree: node 1 is the root, leaves sit at PAD..2*PAD-1.
  logic signed [SW-1:0] w_node [1:2*PAD-1];
  logic signed [SW-1:0] w_root;
  logic                 w_neg;
  logic        [SW-1:0] w_abs;

  genvar g;
  generate
    for (g = 0; g < PAD; g++) begin : g_leaf
      if (g < N_OPERANDS) begin : g_op
        logic signed [SW-1:0] w_mag;
        assign w_mag = {{(LEVELS + 1){1'b0}}, operand[g*WIDTH +: WIDTH-1]};
        assign w_node[PAD+g] = operand[g*WIDTH+WIDTH-1] ? -w_mag : w_mag;
      end else begin : g_pad
        assign w_node[PAD+g] = '0;
      end
    end
    for (g = 1; g < PAD; g++) begin : g_add
      assign w_node[g] = w_node[2*g] + w_node[2*g+1];
    end
  endgenerate

  assign w_root = w_node[1];
  assign w_neg  = w_root[SW-1];
  assign w_abs  = w_neg ? -w_root : w_root;

  // A negative root never has zero magnitude, so zero always comes out as +0.
  always_comb begin
    sum = '0;
    if (w_abs > MAXV) begin
      sum = {w_neg, {(WIDTH - 1){1'b1}}};
    end else begin
      sum = {w_neg, w_abs[WIDTH-2:0]};
    end
  end
endmodule

module tmr_adder_tree #(
  parameter int N_OPERANDS = 8,
  parameter int WIDTH      = 16,
  parameter int INT_BITS   = 6,
  parameter int FRAC_BITS  = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_OPERANDS*WIDTH-1:0] operand,
`ifdef TMR_FAULT_INJECT_EN
  input  logic [1:0]                  fault_sel,
  input  logic [WIDTH-1:0]            fault_mask,
`endif
  output logic                        invalid,
  output logic [WIDTH-1:0]            r
);
  generate
    if (INT_BITS + FRAC_BITS != WIDTH) begin : g_bad_format
      $error("tmr_adder_tree: INT_BITS + FRAC_BITS must equal WIDTH");
    end
    if (N_OPERANDS < 2) begin : g_bad_count
      $error("tmr_adder_tree: N_OPERANDS must be at least 2");
    end
  endgenerate

  (* keep = "true", dont_touch = "true" *) logic [WIDTH-1:0] w_rep [0:2];
  logic [WIDTH-1:0] w_s [0:2];
  logic [WIDTH-1:0] w_vote;
  logic             w_disagree;
  logic [WIDTH-1:0] r_sum;
  logic             r_invalid;

  genvar k;
  generate
    for (k = 0; k < 3; k++) begin : g_rep
      tmr_adder_replica #(
        .N_OPERANDS (N_OPERANDS),
        .WIDTH      (WIDTH)
      ) u_replica (
        .operand (operand),
        .sum     (w_rep[k])
      );
`ifdef TMR_FAULT_INJECT_EN
      assign w_s[k] = w_rep[k] ^ ((fault_sel == 2'(k + 1)) ? fault_mask : '0);
`else
      assign w_s[k] = w_rep[k];
`endif
    end
  endgenerate

  assign w_vote     = (w_s[0] & w_s[1]) | (w_s[1] & w_s[2]) | (w_s[0] & w_s[2]);
  assign w_disagree = (w_s[0] != w_s[1]) | (w_s[1] != w_s[2]) | (w_s[0] != w_s[2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum     <= '0;
      r_invalid <= 1'b0;
    end else begin
      r_sum     <= w_vote;
      r_invalid <= w_disagree;
    end
  end

  assign r       = r_sum;
  assign invalid = r_invalid;
endmodule

// File: tb/tb_tmr_adder_tree.sv
// tb/tb_tmr_adder_tree.sv - directed vector table plus random back-to-back and reset sequences
// Fault-injection sequences are compiled only when TMR_FAULT_INJECT_EN is defined.

module tb_tmr_adder_tree;
  localparam int N = 8;
  localparam int W = 16;

  logic           clk;
  logic           rst_n;
  logic [N*W-1:0] operand;
  logic           invalid;
  logic [W-1:0]   r;
`ifdef TMR_FAULT_INJECT_EN
  logic [1:0]     fault_sel;
  logic [W-1:0]   fault_mask;
`endif

  int n_checks;
  int n_fail;

  tmr_adder_tree #(
    .N_OPERANDS (N),
    .WIDTH      (W),
    .INT_BITS   (6),
    .FRAC_BITS  (10)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .operand    (operand),
`ifdef TMR_FAULT_INJECT_EN
    .fault_sel  (fault_sel),
    .fault_mask (fault_mask),
`endif
    .invalid    (invalid),
    .r          (r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string          name;
    logic [N*W-1:0] op;
    logic [W-1:0]   exp_r;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [W-1:0] model(input logic [N*W-1:0] op);
    int s;
    int m;
    s = 0;
    for (int i = 0; i < N; i++) begin
      m = int'(op[i*W +: W-1]);
      s = op[i*W+W-1] ? s - m : s + m;
    end
    if (s > 32767)  return 16'h7FFF;
    if (s < -32767) return 16'hFFFF;
    if (s < 0)      return {1'b1, 15'(-s)};
    return {1'b0, 15'(s)};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic apply(input logic [N*W-1:0] op);
    @(negedge clk);
    operand = op;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*W-1:0] rand_op();
    logic [N*W-1:0] v;
    logic [W-1:0]   e;
    for (int i = 0; i < N; i++) begin
      e = W'($urandom);
      if ($urandom_range(0, 3) != 0) e = e & 16'h83FF;
      v[i*W +: W] = e;
    end
    return v;
  endfunction

  initial begin
    logic [N*W-1:0] op;
    logic [N*W-1:0] base;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    operand  = '0;
`ifdef TMR_FAULT_INJECT_EN
    fault_sel  = 2'd0;
    fault_mask = '0;
`endif

    base = {16'h007a, 16'h0031, 16'h04d7, 16'h83e1, 16'h81cc, 16'h801b, 16'h0040, 16'h020a};
    vecs.push_back('{"case1_mixed",   base, 16'h0204});
    op = base; op[15:0] = 16'h80f5;
    vecs.push_back('{"case2_neg",     op, 16'h80FB});
    vecs.push_back('{"sat_pos",       {8{16'h7C00}}, 16'h7FFF});
    vecs.push_back('{"sat_neg",       {8{16'hFC00}}, 16'hFFFF});
    vecs.push_back('{"pairs_zero",    {16'h1234, 16'h9234, 16'h0abc, 16'h8abc,
                                       16'h7fff, 16'hffff, 16'h0001, 16'h8001}, 16'h0000});
    vecs.push_back('{"neg_zero_all",  {8{16'h8000}}, 16'h0000});
    vecs.push_back('{"exact_max",     {{7{16'h0000}}, 16'h7FFF}, 16'h7FFF});
    vecs.push_back('{"max_plus_one",  {{6{16'h0000}}, 16'h0001, 16'h7FFF}, 16'h7FFF});
    vecs.push_back('{"min_minus_one", {{6{16'h8000}}, 16'h8001, 16'hFFFF}, 16'hFFFF});
    vecs.push_back('{"split_max",     {{6{16'h0000}}, 16'h4000, 16'h3FFF}, 16'h7FFF});
    vecs.push_back('{"minus_lsb",     {{7{16'h0000}}, 16'h8001}, 16'h8001});
    vecs.push_back('{"top_operand",   {16'h0400, {7{16'h8000}}}, 16'h0400});

    // Asynchronous reset with arbitrary operands present.
    operand = rand_op();
    #2 rst_n = 1'b0;
    #1;
    check("reset_r", r, 16'h0000);
    check("reset_invalid", {15'd0, invalid}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      apply(vecs[i].op);
      check(vecs[i].name, r, vecs[i].exp_r);
      check({vecs[i].name, "_invalid"}, {15'd0, invalid}, 16'd0);
    end

`ifdef TMR_FAULT_INJECT_EN
    @(negedge clk);
    fault_sel  = 2'd2;
    fault_mask = 16'h0001;
    apply(base);
    check("fault_single_r", r, 16'h0204);
    check("fault_single_invalid", {15'd0, invalid}, 16'd1);
    @(negedge clk);
    fault_sel = 2'd0;
    apply(base);
    check("fault_cleared_invalid", {15'd0, invalid}, 16'd0);
    check("fault_cleared_r", r, 16'h0204);
`endif

    // Back-to-back random operands, then reset asserted mid-stream.
    for (int c = 0; c < 100; c++) begin
      op = rand_op();
      apply(op);
      check($sformatf("b2b_%0d", c), r, model(op));
      check($sformatf("b2b_invalid_%0d", c), {15'd0, invalid}, 16'd0);
    end
    @(negedge clk);
    operand = base;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midstream_reset_r", r, 16'h0000);
    check("midstream_reset_invalid", {15'd0, invalid}, 16'd0);
    @(posedge clk);
    #1;
    check("held_in_reset_r", r, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    apply(base);
    check("after_reset_r", r, 16'h0204);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
